// File: rtl/guitar_pkg.sv
// Shared types and default sizing for the rhythm judge blocks.
package guitar_pkg;
    typedef enum logic {IDLE, ARMED} lane_state_t;

    localparam int LANES_DEF        = 4;
    localparam int WINDOW_TICKS_DEF = 8;
    localparam int HIT_POINTS_DEF   = 10;
endpackage

// File: rtl/lane_judge.sv
// Single-lane judge: tracks one armed note and its tick window, emits raw decisions.
module lane_judge
    import guitar_pkg::*;
#(
    parameter int WINDOW_TICKS = WINDOW_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic press_i,
    input  logic note_due_i,
    output logic hit_o,
    output logic miss_o,
    output logic stray_o
);
    localparam int CW = $clog2(WINDOW_TICKS) + 1;
    localparam logic [CW-1:0] LAST = CW'(WINDOW_TICKS - 1);

    lane_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_o   = 1'b0;
        miss_o  = 1'b0;
        stray_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_i && note_due_i) begin
                    hit_o = 1'b1;
                end else if (note_due_i) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end else if (press_i) begin
                    stray_o = 1'b1;
                end
            end
            ARMED: begin
                // Press takes priority over both a new note and window expiry.
                if (press_i) begin
                    hit_o = 1'b1;
                    cnt_d = '0;
                    if (!note_due_i) state_d = IDLE;
                end else if (note_due_i) begin
                    miss_o = 1'b1;
                    cnt_d  = '0;
                end else if (tick_i) begin
                    if (cnt_q == LAST) begin
                        miss_o  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: rtl/note_hit_judge.sv
// Parallel lane judges with registered pulses and saturating score/combo accumulation.
module note_hit_judge
    import guitar_pkg::*;
#(
    parameter int LANES        = LANES_DEF,
    parameter int WINDOW_TICKS = WINDOW_TICKS_DEF,
    parameter int HIT_POINTS   = HIT_POINTS_DEF,
    parameter int SCORE_W      = 16,
    parameter int COMBO_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [LANES-1:0]   press,
    input  logic [LANES-1:0]   note_due,
    output logic [LANES-1:0]   hit,
    output logic [LANES-1:0]   miss,
    output logic [LANES-1:0]   stray,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo
);
    localparam int NHW = $clog2(LANES + 1);

    logic [LANES-1:0]   hit_d, miss_d, stray_d;
    logic [LANES-1:0]   hit_q, miss_q, stray_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [NHW-1:0]     nh;
    logic [SCORE_W:0]   score_sum;
    logic [COMBO_W:0]   combo_sum;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_judge #(.WINDOW_TICKS(WINDOW_TICKS)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick),
            .press_i   (press[g]),
            .note_due_i(note_due[g]),
            .hit_o     (hit_d[g]),
            .miss_o    (miss_d[g]),
            .stray_o   (stray_d[g])
        );
    end

    always_comb begin
        nh = '0;
        for (int i = 0; i < LANES; i++) nh = nh + NHW'(hit_d[i]);
    end

    // Sums are one bit wider than the destination so overflow is visible for clamping.
    always_comb begin
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(int'(nh) * HIT_POINTS);
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        combo_sum = {1'b0, combo_q} + (COMBO_W+1)'(nh);
        if (|miss_d || |stray_d) combo_d = COMBO_W'(nh);
        else                     combo_d = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q   <= '0;
            miss_q  <= '0;
            stray_q <= '0;
            score_q <= '0;
            combo_q <= '0;
        end else begin
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            stray_q <= stray_d;
            score_q <= score_d;
            combo_q <= combo_d;
        end
    end

    assign hit   = hit_q;
    assign miss  = miss_q;
    assign stray = stray_q;
    assign score = score_q;
    assign combo = combo_q;
endmodule

// File: tb/tb_note_hit_judge.sv
// Scoreboard bench for note_hit_judge: expected output tuples queued per driven cycle.
module tb_note_hit_judge;
    localparam int LANES = 4;

    typedef struct packed {
        logic [3:0]  hit;
        logic [3:0]  miss;
        logic [3:0]  stray;
        logic [15:0] score;
        logic [7:0]  combo;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  press = '0, note_due = '0;
    logic [3:0]  hit, miss, stray;
    logic [15:0] score;
    logic [7:0]  combo;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   escore = 0;
    int   ecombo = 0;

    always #5 clk = ~clk;

    note_hit_judge #(.LANES(4), .WINDOW_TICKS(8), .HIT_POINTS(10),
                     .SCORE_W(16), .COMBO_W(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .press(press), .note_due(note_due),
        .hit(hit), .miss(miss), .stray(stray), .score(score), .combo(combo)
    );

    function automatic obs_t mk(input logic [3:0] h, input logic [3:0] m, input logic [3:0] s);
        obs_t o;
        o.hit = h; o.miss = m; o.stray = s;
        o.score = 16'(escore); o.combo = 8'(ecombo);
        return o;
    endfunction

    task automatic drive(input logic r, input logic [3:0] p, input logic [3:0] n,
                         input logic t, input obs_t e);
        obs_t o;
        exp_q.push_back(e);
        rst = r; press = p; note_due = n; tick = t;
        @(posedge clk);
        #1;
        o.hit = hit; o.miss = miss; o.stray = stray; o.score = score; o.combo = combo;
        obs_q.push_back(o);
        rst = 1'b0; press = '0; note_due = '0; tick = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        escore = 0; ecombo = 0;
        drive(1, 4'b0000, 4'b0000, 0, mk(0, 0, 0));
        drive(1, 4'b1111, 4'b1111, 1, mk(0, 0, 0));
        drive(0, 4'b0000, 4'b0000, 0, mk(0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset: got h=%b m=%b s=%b sc=%0d co=%0d, want h=%b m=%b s=%b sc=%0d co=%0d",
                         o.hit, o.miss, o.stray, o.score, o.combo, e.hit, e.miss, e.stray, e.score, e.combo);
            end
        end
    endtask

    task automatic test_hit();
        obs_t e, o;
        drive(0, 4'b0000, 4'b0001, 0, mk(0, 0, 0));
        for (int i = 0; i < 3; i++) drive(0, 4'b0000, 4'b0000, 1, mk(0, 0, 0));
        escore = 10; ecombo = 1;
        drive(0, 4'b0001, 4'b0000, 0, mk(4'b0001, 0, 0));
        drive(0, 4'b0000, 4'b0000, 0, mk(0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL hit: got h=%b m=%b s=%b sc=%0d co=%0d, want h=%b m=%b s=%b sc=%0d co=%0d",
                         o.hit, o.miss, o.stray, o.score, o.combo, e.hit, e.miss, e.stray, e.score, e.combo);
            end
        end
    endtask

    task automatic test_miss();
        obs_t e, o;
        drive(0, 4'b0000, 4'b0010, 0, mk(0, 0, 0));
        for (int i = 0; i < 7; i++) drive(0, 4'b0000, 4'b0000, 1, mk(0, 0, 0));
        ecombo = 0;
        drive(0, 4'b0000, 4'b0000, 1, mk(0, 4'b0010, 0));
        drive(0, 4'b0000, 4'b0000, 1, mk(0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL miss: got h=%b m=%b s=%b sc=%0d co=%0d, want h=%b m=%b s=%b sc=%0d co=%0d",
                         o.hit, o.miss, o.stray, o.score, o.combo, e.hit, e.miss, e.stray, e.score, e.combo);
            end
        end
    endtask

    task automatic test_stray();
        obs_t e, o;
        for (int i = 0; i < 5; i++) begin
            escore += 10; ecombo += 1;
            drive(0, 4'b0001, 4'b0001, 0, mk(4'b0001, 0, 0));
        end
        ecombo = 0;
        drive(0, 4'b0100, 4'b0000, 0, mk(0, 0, 4'b0100));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL stray: got h=%b m=%b s=%b sc=%0d co=%0d, want h=%b m=%b s=%b sc=%0d co=%0d",
                         o.hit, o.miss, o.stray, o.score, o.combo, e.hit, e.miss, e.stray, e.score, e.combo);
            end
        end
    endtask

    task automatic test_all_lanes();
        obs_t e, o;
        drive(0, 4'b0000, 4'b1111, 0, mk(0, 0, 0));
        escore += 40; ecombo += 4;
        drive(0, 4'b1111, 4'b0000, 0, mk(4'b1111, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL all_lanes: got h=%b m=%b s=%b sc=%0d co=%0d, want h=%b m=%b s=%b sc=%0d co=%0d",
                         o.hit, o.miss, o.stray, o.score, o.combo, e.hit, e.miss, e.stray, e.score, e.combo);
            end
        end
    endtask

    task automatic test_edge_window();
        obs_t e, o;
        drive(0, 4'b0000, 4'b0001, 0, mk(0, 0, 0));
        for (int i = 0; i < 7; i++) drive(0, 4'b0000, 4'b0000, 1, mk(0, 0, 0));
        escore += 10; ecombo += 1;
        drive(0, 4'b0001, 4'b0000, 1, mk(4'b0001, 0, 0));
        drive(0, 4'b0000, 4'b0001, 0, mk(0, 0, 0));
        ecombo = 0;
        drive(0, 4'b0000, 4'b0001, 0, mk(0, 4'b0001, 0));
        drive(0, 4'b0000, 4'b0010, 0, mk(0, 0, 0));
        escore += 10; ecombo = 1;
        drive(0, 4'b0001, 4'b0010, 0, mk(4'b0001, 4'b0010, 0));
        escore += 10; ecombo += 1;
        drive(0, 4'b0010, 4'b0000, 0, mk(4'b0010, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL edge_window: got h=%b m=%b s=%b sc=%0d co=%0d, want h=%b m=%b s=%b sc=%0d co=%0d",
                         o.hit, o.miss, o.stray, o.score, o.combo, e.hit, e.miss, e.stray, e.score, e.combo);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        while (escore + 40 <= 65530) begin
            escore += 40;
            ecombo = (ecombo + 4 > 255) ? 255 : ecombo + 4;
            drive(0, 4'b1111, 4'b1111, 0, mk(4'b1111, 0, 0));
        end
        while (escore < 65530) begin
            escore += 10;
            ecombo = (ecombo + 1 > 255) ? 255 : ecombo + 1;
            drive(0, 4'b0001, 4'b0001, 0, mk(4'b0001, 0, 0));
        end
        escore = 65535;
        drive(0, 4'b0001, 4'b0001, 0, mk(4'b0001, 0, 0));
        drive(0, 4'b0011, 4'b0011, 0, mk(4'b0011, 0, 0));
        drive(0, 4'b0000, 4'b1000, 0, mk(0, 0, 0));
        drive(0, 4'b0000, 4'b0000, 1, mk(0, 0, 0));
        escore = 0; ecombo = 0;
        drive(1, 4'b0000, 4'b0000, 1, mk(0, 0, 0));
        for (int i = 0; i < 10; i++) drive(0, 4'b0000, 4'b0000, 1, mk(0, 0, 0));
        escore = 10; ecombo = 1;
        drive(0, 4'b1000, 4'b1000, 0, mk(4'b1000, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL back_to_back: got h=%b m=%b s=%b sc=%0d co=%0d, want h=%b m=%b s=%b sc=%0d co=%0d",
                         o.hit, o.miss, o.stray, o.score, o.combo, e.hit, e.miss, e.stray, e.score, e.combo);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_hit();
        test_miss();
        test_stray();
        test_all_lanes();
        test_edge_window();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
